// File: rtl/key_debounce_if.sv
// Button-side signal bundle for key_debounce: raw pad in, debounced events out.
interface key_debounce_if;
  logic       key_n;        // raw pad, 0 = pressed
  logic       key_level;    // debounced level, 1 = pressed
  logic       key_press;    // one-cycle pulse on qualified press
  logic       key_release;  // one-cycle pulse on qualified release
  logic       key_toggle;   // flips on every qualified press
  logic [7:0] press_count;  // qualified presses, modulo 256

  // Board / testbench side: drives the pad, observes events.
  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_toggle,
    input  press_count
  );

  // Debouncer side.
  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output key_toggle,
    output press_count
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchroniser, four-state qualification FSM,
// registered press/release pulses, press-toggled bit and wrapping press count.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic          clk,
  input  logic          rst,
  key_debounce_if.slave kif
);

  // Last counter value of a filter window; an edge qualifies one cycle after it.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressFilt,
    StPressed,
    StRelFilt
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, key_s_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;
  logic [7:0]       count_q, count_d;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b1;
      key_s_q <= 1'b1;
    end else begin
      s1_q    <= kif.key_n;
      key_s_q <= s1_q;
    end
  end

  // Next-state logic: filter windows, aborts and qualified-edge actions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    count_d   = count_q;
    case (state_q)
      StIdle: begin
        if (!key_s_q) begin
          state_d = StPressFilt;
          cnt_d   = '0;
        end
      end
      StPressFilt: begin
        if (key_s_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = StPressed;
          cnt_d    = '0;
          press_d  = 1'b1;
          level_d  = 1'b1;
          toggle_d = ~toggle_q;
          count_d  = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPressed: begin
        if (key_s_q) begin
          state_d = StRelFilt;
          cnt_d   = '0;
        end
      end
      StRelFilt: begin
        if (!key_s_q) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      count_q   <= count_d;
    end
  end

  assign kif.key_level   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.key_toggle  = toggle_q;
  assign kif.press_count = count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with DEBOUNCE_CYCLES=8, CNT_W=4.
module tb_key_debounce;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_debounce_if kif();

  key_debounce #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the level flips once N+1 consecutive synchronised samples
  // disagree with it; the synchronised sample is the pad value two edges back.
  logic [1:0] m_hist    = 2'b11;
  int         m_run     = 0;
  logic       m_level   = 1'b0;
  logic       m_press   = 1'b0;
  logic       m_release = 1'b0;
  logic       m_toggle  = 1'b0;
  logic [7:0] m_count   = 8'd0;
  logic       m_smp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hist = 2'b11; m_run = 0; m_level = 1'b0; m_press = 1'b0;
      m_release = 1'b0; m_toggle = 1'b0; m_count = 8'd0;
    end else begin
      m_smp     = ~m_hist[1];  // 1 = pressed
      m_hist    = {m_hist[0], kif.key_n};
      m_press   = 1'b0;
      m_release = 1'b0;
      if (m_smp != m_level) m_run = m_run + 1;
      else m_run = 0;
      if (m_run == int'(N) + 1) begin
        m_run   = 0;
        m_level = m_smp;
        if (m_smp) begin
          m_press  = 1'b1;
          m_toggle = ~m_toggle;
          m_count  = 8'((int'(m_count) + 1) % 256);
        end else begin
          m_release = 1'b1;
        end
      end
    end
  end

  function automatic logic [11:0] dut_vec();
    return {kif.key_level, kif.key_press, kif.key_release, kif.key_toggle, kif.press_count};
  endfunction

  function automatic logic [11:0] model_vec();
    return {m_level, m_press, m_release, m_toggle, m_count};
  endfunction

  // One cycle: present the pad value, return at the following negedge.
  task automatic tick(input logic kn);
    kif.key_n = kn;
    @(negedge clk);
  endtask

  task automatic do_reset();
    kif.key_n = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) tick(1'b1);
  endtask

  task automatic test_reset();
    kif.key_n = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut_vec() !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), 12'h000);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      n_cmp++;
      if (dut_vec() !== 12'h000) begin
        n_bad++; $display("FAIL reset_idle: got %h want %h", dut_vec(), 12'h000);
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int npress = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL clean_high: got %h want %h", dut_vec(), model_vec());
      end
    end
    for (int k = 0; k < 14; k++) begin  // k = edge index, 0 = first low sample
      tick(1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL clean_press_cycle: k=%0d got %h want %h", k, dut_vec(), model_vec());
      end
      if (kif.key_press) begin
        npress++;
        if (first < 0) first = k;
      end
    end
    n_cmp++;
    if (first != 10 || npress != 1) begin
      n_bad++; $display("FAIL clean_press_edge: got edge %0d x%0d want edge 10 x1", first, npress);
    end
    n_cmp++;
    if ({kif.key_level, kif.key_toggle, kif.press_count} !== {1'b1, 1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL clean_press_state: got %b%b/%0d want 11/1", kif.key_level, kif.key_toggle,
               kif.press_count);
    end
  endtask

  task automatic test_bouncy_press();
    logic [4:0] bounce = 5'b10010;  // applied LSB first: 0,1,0,0,1
    int first = -1;
    int npress = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(bounce[i]);
      n_cmp++;
      if (kif.key_press || kif.key_release || dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL bounce_quiet: got %h want %h", dut_vec(), model_vec());
      end
    end
    for (int k = 0; k < 14; k++) begin
      tick(1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL bounce_cycle: k=%0d got %h want %h", k, dut_vec(), model_vec());
      end
      if (kif.key_press) begin
        npress++;
        if (first < 0) first = k;
      end
    end
    n_cmp++;
    if (first != 10 || npress != 1 || kif.press_count !== 8'd1) begin
      n_bad++;
      $display("FAIL bounce_press: got edge %0d x%0d cnt %0d want edge 10 x1 cnt 1", first, npress,
               kif.press_count);
    end
  endtask

  // Entered while PRESSED (after test_bouncy_press).
  task automatic test_release_abort();
    int nrel = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 5 ? 1'b1 : 1'b0);
      n_cmp++;
      if (kif.key_release || !kif.key_level || dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL rel_abort: i=%0d got %h want %h", i, dut_vec(), model_vec());
      end
    end
    for (int i = 0; i < 14; i++) begin
      tick(1'b1);
      if (kif.key_release) nrel++;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL rel_stable: i=%0d got %h want %h", i, dut_vec(), model_vec());
      end
    end
    n_cmp++;
    if (nrel != 1 || kif.key_level !== 1'b0) begin
      n_bad++; $display("FAIL rel_count: got %0d lvl %b want 1 lvl 0", nrel, kif.key_level);
    end
  endtask

  task automatic test_wrap();
    int npress = 0;
    int nrel = 0;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 24; i++) begin
        tick(i < 12 ? 1'b0 : 1'b1);
        if (kif.key_press) npress++;
        if (kif.key_release) nrel++;
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_bad++; $display("FAIL wrap_cycle: p=%0d got %h want %h", p, dut_vec(), model_vec());
        end
      end
    end
    n_cmp++;
    if (kif.press_count !== 8'd0 || kif.key_toggle !== 1'b0 || npress != 256 || nrel != 256) begin
      n_bad++;
      $display("FAIL wrap_end: got cnt %0d tog %b p %0d r %0d want 0 0 256 256", kif.press_count,
               kif.key_toggle, npress, nrel);
    end
  endtask

  task automatic test_glitch();
    logic [11:0] snap;
    snap = dut_vec();
    tick(1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1'b1);
      n_cmp++;
      if (dut_vec() !== snap || dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL glitch: got %h want %h", dut_vec(), snap);
      end
    end
  endtask

  task automatic reset_then_press(input string tag);
    int first = -1;
    int nrel = 0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 12'h000) begin
      n_bad++; $display("FAIL %s_in_reset: got %h want 000", tag, dut_vec());
    end
    @(negedge clk);
    n_cmp++;
    if (dut_vec() !== 12'h000) begin
      n_bad++; $display("FAIL %s_held_reset: got %h want 000", tag, dut_vec());
    end
    rst = 1'b1;
    for (int k = 0; k < 14; k++) begin  // k = 0 is the first edge after release
      tick(1'b0);
      if (kif.key_release) nrel++;
      if (kif.key_press && first < 0) first = k;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL %s_cycle: k=%0d got %h want %h", tag, k, dut_vec(), model_vec());
      end
    end
    n_cmp++;
    if (first != 10 || nrel != 0 || kif.press_count !== 8'd1) begin
      n_bad++;
      $display("FAIL %s_requal: got edge %0d rel %0d cnt %0d want 10 0 1", tag, first, nrel,
               kif.press_count);
    end
  endtask

  task automatic test_reset_mid();
    repeat (12) tick(1'b0);  // qualified press: level 1, toggle/count nonzero
    n_cmp++;
    if (kif.key_level !== 1'b1) begin
      n_bad++; $display("FAIL pressed_before_reset: got %b want 1", kif.key_level);
    end
    reset_then_press("rst_pressed");
    repeat (14) tick(1'b1);
    repeat (8) tick(1'b0);   // edges 0..7: mid press filter, counter at 5
    reset_then_press("rst_filter");
    repeat (14) tick(1'b1);
  endtask

  task automatic test_random();
    logic prev = 1'b0;
    logic kn;
    int len;
    for (int s = 0; s < 80; s++) begin
      kn  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) begin
        tick(kn);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_bad++; $display("FAIL rand_cycle: s=%0d got %h want %h", s, dut_vec(), model_vec());
        end
        n_cmp++;
        if ((kif.key_press && kif.key_release) || (prev && (kif.key_press || kif.key_release))) begin
          n_bad++;
          $display("FAIL rand_pulse_rule: got p%b r%b prev %b want no overlap", kif.key_press,
                   kif.key_release, prev);
        end
        prev = kif.key_press | kif.key_release;
      end
    end
  endtask

  initial begin
    kif.key_n = 1'b1;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_release_abort();
    test_wrap();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
